game_tick_scheduler: RTL

Replaces derived slow clocks with single-cycle enable strobes on the 100 MHz domain. It provides three independently programmable tick channels: ch0 game-logic frame, ch1 sprite animation, ch2 input sampling. It adds a global pause and a hit-stop freeze that halts game logic and animation while input sampling keeps running. It sits between the top-level clock and every game subsystem, and is reconfigured at runtime through a valid/ready port.

---
 rtl/game_tick_scheduler.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_tick_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : game_tick_scheduler
//  Purpose  : Generates single-cycle enable strobes for the game subsystems
//             from the one 100 MHz clock, so no derived slow clocks are used.
//             Three programmable tick channels:
//               ch0 - game-logic frame
//               ch1 - sprite animation
//               ch2 - input sampling
//             A global pause freezes every channel. A hit-stop freezes ch0
//             and ch1 for a number of ch2 ticks while input sampling keeps
//             running. Channel periods are reprogrammed at runtime through
//             a valid/ready port with a single pending slot.
//
//  Ports    : clk_in          in   1      sole clock
//             rst             in   1      synchronous, active-high reset
//             cfg_valid       in   1      config request
//             cfg_ready       out  1      scheduler can accept a config
//             cfg_ch          in   2      target channel (3 = discarded)
//             cfg_period      in   CNT_W  new period (0 = channel disabled)
//             pause           in   1      level, freezes all channels
//             hitstop_start   in   1      single-cycle hit-stop request
//             hitstop_frames  in   8      hit-stop length in ch2 ticks
//             tick            out  3      one-cycle strobes, bit i = ch i
//             hitstop_active  out  1      hit-stop in progress
//             frame_count     out  16     count of ch0 ticks (wraps)
//
//  Revision : 1.0  initial release
// ============================================================================
module game_tick_scheduler #(
    parameter int CNT_W   = 24,
    parameter int PERIOD0 = 1_428_571,
    parameter int PERIOD1 = 8_333_333,
    parameter int PERIOD2 = 1_000_000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             pause,
    input  logic             hitstop_start,
    input  logic [7:0]       hitstop_frames,
    output logic [2:0]       tick,
    output logic             hitstop_active,
    output logic [15:0]      frame_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               C_NUM_CH     = 3;
    localparam logic [1:0]       C_CH_INVALID = 2'd3;
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ZERO   = '0;

    localparam logic [CNT_W-1:0] C_RESET_PERIOD [C_NUM_CH] = '{
        CNT_W'(PERIOD0),
        CNT_W'(PERIOD1),
        CNT_W'(PERIOD2)
    };

    // Hit-stop FSM encoding
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } hs_state_t;

    // ------------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------------
    hs_state_t        r_state;
    hs_state_t        w_state_nxt;
    logic [7:0]       r_remain;
    logic [7:0]       w_remain_nxt;
    logic             w_hold;

    logic             r_pend_valid;
    logic [1:0]       r_pend_ch;
    logic [CNT_W-1:0] r_pend_period;
    logic             w_cfg_fire;

    logic [2:0]       w_frz;      // per-channel freeze condition
    logic [2:0]       w_wrap;     // channel wraps (and ticks) on this edge
    logic [2:0]       w_apply;    // pending period lands on this channel now

    logic [2:0]       r_tick;
    logic [15:0]      r_frame;

    // ------------------------------------------------------------------------
    // Freeze conditions
    // Pause stops everything; hit-stop stops game logic and animation but
    // input sampling (ch2) keeps running, since it drives the countdown.
    // ------------------------------------------------------------------------
    assign w_hold = (r_state == S_HOLD);
    assign w_frz  = {pause, pause || w_hold, pause || w_hold};

    // ------------------------------------------------------------------------
    // Tick channels
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] r_period;
        logic [CNT_W-1:0] r_cnt;
        logic             w_enabled;
        logic             w_advance;
        logic             w_target;

        assign w_enabled = (r_period != C_CNT_ZERO);
        assign w_advance = w_enabled && !w_frz[gi];

        // A frozen counter sitting at period-1 does not wrap; it waits until
        // the freeze lifts, and any pending period waits with it.
        assign w_wrap[gi] = w_advance && (r_cnt == (r_period - C_CNT_ONE));

        // The pending value lands on the wrap edge so the old-period tick
        // still fires and the counter restarts cleanly at 0. A disabled
        // channel has no wrap to wait for, so it takes the value at once
        // unless paused.
        assign w_target     = r_pend_valid && (r_pend_ch == 2'(gi));
        assign w_apply[gi]  = w_target && !pause && (w_wrap[gi] || !w_enabled);

        always_ff @(posedge clk_in) begin
            if (rst) begin
                r_period <= C_RESET_PERIOD[gi];
                r_cnt    <= C_CNT_ZERO;
            end else begin
                if (w_wrap[gi]) begin
                    r_cnt <= C_CNT_ZERO;
                end else if (w_advance) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end

                if (w_apply[gi]) begin
                    r_period <= r_pend_period;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Config pending slot
    // cfg_ready is purely the slot state so it never combinationally depends
    // on cfg_valid. A request for channel 3 completes the handshake but is
    // dropped, leaving the slot empty and cfg_ready high.
    // ------------------------------------------------------------------------
    assign cfg_ready  = !r_pend_valid;
    assign w_cfg_fire = cfg_valid && cfg_ready;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_ch     <= 2'd0;
            r_pend_period <= C_CNT_ZERO;
        end else begin
            if (w_cfg_fire && (cfg_ch != C_CH_INVALID)) begin
                r_pend_valid  <= 1'b1;
                r_pend_ch     <= cfg_ch;
                r_pend_period <= cfg_period;
            end else if (|w_apply) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Hit-stop FSM
    // The countdown consumes the registered ch2 strobe, so the strobe that
    // takes the count from 1 to 0 is visible while hitstop_active is still
    // high and the freeze releases on the following cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_remain <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        case (r_state)
            S_IDLE: begin
                if (hitstop_start && (hitstop_frames != 8'd0)) begin
                    w_state_nxt  = S_HOLD;
                    w_remain_nxt = hitstop_frames;
                end
            end
            S_HOLD: begin
                // New start requests are ignored here: no extension.
                if (r_tick[2]) begin
                    w_remain_nxt = r_remain - 8'd1;
                    if (r_remain == 8'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_tick  <= 3'b000;
            r_frame <= 16'd0;
        end else begin
            r_tick <= w_wrap;
            if (w_wrap[0]) begin
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    assign tick           = r_tick;
    assign hitstop_active = w_hold;
    assign frame_count    = r_frame;

endmodule
`default_nettype wire
